// File: rtl/branch_predictor_if.sv
// Fetch/decode/execute-side signals of the branch predictor, bundled with
// modports for the predictor (slave) and the pipeline driving it (master).
interface branch_predictor_if;
    logic        stall;
    logic [31:0] pc_f;
    logic        d_branch;
    logic [31:0] d_pc;
    logic [31:0] d_target;
    logic        d_pred_taken;
    logic        x_valid;
    logic [31:0] x_pc;
    logic [31:0] x_target;
    logic        x_taken;
    logic        x_pred;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        kill_fd;
    logic        kill_dx;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    modport slave (
        input  stall, d_branch, d_pc, d_target,
        input  x_valid, x_pc, x_target, x_taken, x_pred,
        input  jump_valid, jump_target,
        output pc_f, d_pred_taken, kill_fd, kill_dx, branch_cnt, mispred_cnt
    );

    modport master (
        output stall, d_branch, d_pc, d_target,
        output x_valid, x_pc, x_target, x_taken, x_pred,
        output jump_valid, jump_target,
        input  pc_f, d_pred_taken, kill_fd, kill_dx, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// Fetch PC generation with a direct-mapped 2-bit saturating-counter branch
// predictor, execute-stage misprediction/jump redirect and perf counters.
module branch_predictor #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter int          IDX_BITS = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bp
);
    localparam int DEPTH = 1 << IDX_BITS;

    logic [31:0]         pc_q, pc_d;
    logic [31:0]         branch_cnt_q, branch_cnt_d;
    logic [31:0]         mispred_cnt_q, mispred_cnt_d;
    logic [1:0]          ctr_q [DEPTH];
    logic [1:0]          ctr_d [DEPTH];
    logic [IDX_BITS-1:0] d_idx, x_idx;
    logic                pred_taken, mis;
    logic [31:0]         correct_pc;
    logic                kill_fd, kill_dx;

    always_comb begin
        d_idx      = bp.d_pc[IDX_BITS+1:2];
        x_idx      = bp.x_pc[IDX_BITS+1:2];
        pred_taken = bp.d_branch & ctr_q[d_idx][1];
        mis        = bp.x_valid & (bp.x_taken != bp.x_pred);
        correct_pc = bp.x_taken ? bp.x_target : bp.x_pc + 32'd4;

        pc_d    = pc_q + 32'd4;
        kill_fd = 1'b0;
        kill_dx = 1'b0;
        // Execute-stage redirects outrank the stall; a predicted-taken
        // redirect only applies while the decode instruction is advancing.
        if (mis) begin
            pc_d    = correct_pc;
            kill_fd = 1'b1;
            kill_dx = 1'b1;
        end else if (bp.jump_valid) begin
            pc_d    = bp.jump_target;
            kill_fd = 1'b1;
            kill_dx = 1'b1;
        end else if (bp.stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d    = bp.d_target;
            kill_fd = 1'b1;
        end
        if (!rst_n) begin
            kill_fd = 1'b0;
            kill_dx = 1'b0;
        end

        branch_cnt_d  = branch_cnt_q + {31'd0, bp.x_valid};
        mispred_cnt_d = mispred_cnt_q + {31'd0, mis};
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ctr
            logic hit;
            assign hit = bp.x_valid && (x_idx == IDX_BITS'(gi));

            always_comb begin
                ctr_d[gi] = ctr_q[gi];
                if (hit) begin
                    if (bp.x_taken && ctr_q[gi] != 2'b11)
                        ctr_d[gi] = ctr_q[gi] + 2'd1;
                    else if (!bp.x_taken && ctr_q[gi] != 2'b00)
                        ctr_d[gi] = ctr_q[gi] - 2'd1;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) ctr_q[gi] <= 2'b01;
                else        ctr_q[gi] <= ctr_d[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            branch_cnt_q  <= 32'd0;
            mispred_cnt_q <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bp.pc_f         = pc_q;
    assign bp.d_pred_taken = pred_taken;
    assign bp.kill_fd      = kill_fd;
    assign bp.kill_dx      = kill_dx;
    assign bp.branch_cnt   = branch_cnt_q;
    assign bp.mispred_cnt  = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor: reset, training and
// saturation, mispredict redirect, priority, aliasing and PC wrap.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] exp_bcnt = 32'd0;
    logic [31:0] exp_mcnt = 32'd0;

    branch_predictor_if bif ();

    branch_predictor #(.RESET_PC(32'h4000_0000), .IDX_BITS(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bif)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bif.stall = 0; bif.d_branch = 0; bif.d_pc = 0; bif.d_target = 0;
        bif.x_valid = 0; bif.x_pc = 0; bif.x_target = 0; bif.x_taken = 0;
        bif.x_pred = 0; bif.jump_valid = 0; bif.jump_target = 0;
    endtask

    // One resolved branch for one cycle; expected perf counts follow along.
    task automatic pulse_branch(input logic [31:0] pc, input logic taken, input logic pred);
        bif.x_valid = 1; bif.x_pc = pc; bif.x_target = pc + 32'h100;
        bif.x_taken = taken; bif.x_pred = pred;
        tick();
        bif.x_valid = 0;
        exp_bcnt = exp_bcnt + 1;
        if (taken != pred) exp_mcnt = exp_mcnt + 1;
    endtask

    task automatic test_reset;
        idle();
        rst_n = 0; bif.jump_valid = 1; bif.jump_target = 32'h1234_5678;
        #1;
        n_cmp++; if (bif.kill_fd !== 1'b0) begin n_bad++; $display("FAIL rst_kill_fd got %b want 0", bif.kill_fd); end
        tick(); tick();
        n_cmp++; if (bif.pc_f !== 32'h4000_0000) begin n_bad++; $display("FAIL rst_pc got %h want 40000000", bif.pc_f); end
        n_cmp++; if (bif.branch_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_bcnt got %h want 0", bif.branch_cnt); end
        n_cmp++; if (bif.mispred_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_mcnt got %h want 0", bif.mispred_cnt); end
        idle(); rst_n = 1; bif.d_branch = 1; bif.d_pc = 32'h4000_0040; bif.d_target = 32'h4000_1000;
        #1;
        n_cmp++; if (bif.d_pred_taken !== 1'b0) begin n_bad++; $display("FAIL rst_pred got %b want 0", bif.d_pred_taken); end
        tick();
        n_cmp++; if (bif.pc_f !== 32'h4000_0004) begin n_bad++; $display("FAIL rst_pc1 got %h want 40000004", bif.pc_f); end
        tick();
        n_cmp++; if (bif.pc_f !== 32'h4000_0008) begin n_bad++; $display("FAIL rst_pc2 got %h want 40000008", bif.pc_f); end
        idle();
        $display("test_reset done");
    endtask

    task automatic test_training;
        pulse_branch(32'h4000_0040, 1, 1);
        pulse_branch(32'h4000_0040, 1, 1);
        bif.d_branch = 1; bif.d_pc = 32'h4000_0040; bif.d_target = 32'h4000_1000;
        #1;
        n_cmp++; if (bif.d_pred_taken !== 1'b1) begin n_bad++; $display("FAIL train_pred_t got %b want 1", bif.d_pred_taken); end
        n_cmp++; if (bif.kill_fd !== 1'b1) begin n_bad++; $display("FAIL train_kill_fd got %b want 1", bif.kill_fd); end
        n_cmp++; if (bif.kill_dx !== 1'b0) begin n_bad++; $display("FAIL train_kill_dx got %b want 0", bif.kill_dx); end
        tick();
        n_cmp++; if (bif.pc_f !== 32'h4000_1000) begin n_bad++; $display("FAIL train_redirect got %h want 40001000", bif.pc_f); end
        bif.d_branch = 0;
        pulse_branch(32'h4000_0040, 1, 1);   // saturate at 11
        bif.d_branch = 1; #1;
        n_cmp++; if (bif.d_pred_taken !== 1'b1) begin n_bad++; $display("FAIL train_sat_hi got %b want 1", bif.d_pred_taken); end
        bif.d_branch = 0;
        pulse_branch(32'h4000_0040, 0, 0);   // 10
        bif.d_branch = 1; #1;
        n_cmp++; if (bif.d_pred_taken !== 1'b1) begin n_bad++; $display("FAIL train_nt1 got %b want 1", bif.d_pred_taken); end
        bif.d_branch = 0;
        pulse_branch(32'h4000_0040, 0, 0);   // 01
        pulse_branch(32'h4000_0040, 0, 0);   // 00
        bif.d_branch = 1; #1;
        n_cmp++; if (bif.d_pred_taken !== 1'b0) begin n_bad++; $display("FAIL train_nt3 got %b want 0", bif.d_pred_taken); end
        bif.d_branch = 0;
        pulse_branch(32'h4000_0040, 0, 0);   // stays 00
        bif.d_branch = 1; #1;
        n_cmp++; if (bif.d_pred_taken !== 1'b0) begin n_bad++; $display("FAIL train_sat_lo got %b want 0", bif.d_pred_taken); end
        n_cmp++; if (bif.branch_cnt !== exp_bcnt) begin n_bad++; $display("FAIL train_bcnt got %h want %h", bif.branch_cnt, exp_bcnt); end
        idle();
        $display("test_training done");
    endtask

    task automatic test_mispredict;
        bif.x_valid = 1; bif.x_pc = 32'h4000_0100; bif.x_target = 32'h4000_0800;
        bif.x_taken = 0; bif.x_pred = 1;
        #1;
        n_cmp++; if (bif.kill_fd !== 1'b1) begin n_bad++; $display("FAIL mis_kill_fd got %b want 1", bif.kill_fd); end
        n_cmp++; if (bif.kill_dx !== 1'b1) begin n_bad++; $display("FAIL mis_kill_dx got %b want 1", bif.kill_dx); end
        tick();
        exp_bcnt = exp_bcnt + 1; exp_mcnt = exp_mcnt + 1;
        n_cmp++; if (bif.pc_f !== 32'h4000_0104) begin n_bad++; $display("FAIL mis_pc_nt got %h want 40000104", bif.pc_f); end
        n_cmp++; if (bif.mispred_cnt !== exp_mcnt) begin n_bad++; $display("FAIL mis_mcnt got %h want %h", bif.mispred_cnt, exp_mcnt); end
        n_cmp++; if (bif.branch_cnt !== exp_bcnt) begin n_bad++; $display("FAIL mis_bcnt got %h want %h", bif.branch_cnt, exp_bcnt); end
        bif.x_pc = 32'h4000_0104; bif.x_target = 32'h4000_0900; bif.x_taken = 1; bif.x_pred = 0;
        tick();
        exp_bcnt = exp_bcnt + 1; exp_mcnt = exp_mcnt + 1;
        n_cmp++; if (bif.pc_f !== 32'h4000_0900) begin n_bad++; $display("FAIL mis_pc_t got %h want 40000900", bif.pc_f); end
        n_cmp++; if (bif.mispred_cnt !== exp_mcnt) begin n_bad++; $display("FAIL mis_mcnt2 got %h want %h", bif.mispred_cnt, exp_mcnt); end
        idle();
        $display("test_mispredict done");
    endtask

    task automatic test_priority;
        bif.jump_valid = 1; bif.jump_target = 32'h4000_0500;
        tick();
        n_cmp++; if (bif.pc_f !== 32'h4000_0500) begin n_bad++; $display("FAIL pri_jump got %h want 40000500", bif.pc_f); end
        idle();
        bif.stall = 1; bif.d_branch = 1; bif.d_pc = 32'h4000_0104; bif.d_target = 32'h4000_0300;
        #1;
        n_cmp++; if (bif.d_pred_taken !== 1'b1) begin n_bad++; $display("FAIL pri_stall_pred got %b want 1", bif.d_pred_taken); end
        n_cmp++; if ({bif.kill_fd, bif.kill_dx} !== 2'b00) begin n_bad++; $display("FAIL pri_stall_kill got %b want 00", {bif.kill_fd, bif.kill_dx}); end
        tick();
        n_cmp++; if (bif.pc_f !== 32'h4000_0500) begin n_bad++; $display("FAIL pri_stall_hold got %h want 40000500", bif.pc_f); end
        bif.jump_valid = 1; bif.jump_target = 32'h4000_0200;
        #1;
        n_cmp++; if ({bif.kill_fd, bif.kill_dx} !== 2'b11) begin n_bad++; $display("FAIL pri_jump_kill got %b want 11", {bif.kill_fd, bif.kill_dx}); end
        tick();
        n_cmp++; if (bif.pc_f !== 32'h4000_0200) begin n_bad++; $display("FAIL pri_jump_stall got %h want 40000200", bif.pc_f); end
        // mispredict beats a simultaneous jump and the stall
        bif.jump_target = 32'h4000_0600;
        bif.x_valid = 1; bif.x_pc = 32'h4000_0104; bif.x_target = 32'h4000_0700; bif.x_taken = 1; bif.x_pred = 0;
        tick();
        exp_bcnt = exp_bcnt + 1; exp_mcnt = exp_mcnt + 1;
        n_cmp++; if (bif.pc_f !== 32'h4000_0700) begin n_bad++; $display("FAIL pri_mis_jump got %h want 40000700", bif.pc_f); end
        n_cmp++; if (bif.mispred_cnt !== exp_mcnt) begin n_bad++; $display("FAIL pri_mcnt got %h want %h", bif.mispred_cnt, exp_mcnt); end
        bif.x_valid = 0; bif.jump_valid = 0; bif.stall = 0;
        #1;
        n_cmp++; if ({bif.kill_fd, bif.kill_dx} !== 2'b10) begin n_bad++; $display("FAIL pri_pred_kill got %b want 10", {bif.kill_fd, bif.kill_dx}); end
        tick();
        n_cmp++; if (bif.pc_f !== 32'h4000_0300) begin n_bad++; $display("FAIL pri_pred_pc got %h want 40000300", bif.pc_f); end
        bif.d_branch = 0;
        #1;
        n_cmp++; if (bif.d_pred_taken !== 1'b0) begin n_bad++; $display("FAIL pri_nobranch got %b want 0", bif.d_pred_taken); end
        tick();
        n_cmp++; if (bif.pc_f !== 32'h4000_0304) begin n_bad++; $display("FAIL pri_seq got %h want 40000304", bif.pc_f); end
        idle();
        $display("test_priority done");
    endtask

    task automatic test_alias;
        pulse_branch(32'h4000_0080, 1, 1);   // index 0: 00 -> 01
        pulse_branch(32'h4000_0080, 1, 1);   // 01 -> 10
        bif.d_branch = 1; bif.d_pc = 32'h4000_0000;
        #1;
        n_cmp++; if (bif.d_pred_taken !== 1'b1) begin n_bad++; $display("FAIL alias_pred got %b want 1", bif.d_pred_taken); end
        bif.d_pc = 32'h4000_0080; bif.d_target = 32'h4000_0A00;
        bif.x_valid = 1; bif.x_pc = 32'h4000_0000; bif.x_taken = 0; bif.x_pred = 0;
        #1;
        n_cmp++; if (bif.d_pred_taken !== 1'b1) begin n_bad++; $display("FAIL alias_same_cycle got %b want 1", bif.d_pred_taken); end
        tick();
        exp_bcnt = exp_bcnt + 1;
        bif.x_valid = 0;
        n_cmp++; if (bif.pc_f !== 32'h4000_0A00) begin n_bad++; $display("FAIL alias_pc got %h want 40000a00", bif.pc_f); end
        bif.d_pc = 32'h4000_0000;
        #1;
        n_cmp++; if (bif.d_pred_taken !== 1'b0) begin n_bad++; $display("FAIL alias_after got %b want 0", bif.d_pred_taken); end
        n_cmp++; if (bif.branch_cnt !== exp_bcnt) begin n_bad++; $display("FAIL alias_bcnt got %h want %h", bif.branch_cnt, exp_bcnt); end
        idle();
        $display("test_alias done");
    endtask

    task automatic test_wrap;
        bif.x_valid = 1; bif.x_pc = 32'hFFFF_FFFC; bif.x_target = 32'h4000_0000; bif.x_taken = 0; bif.x_pred = 1;
        tick();
        exp_bcnt = exp_bcnt + 1; exp_mcnt = exp_mcnt + 1;
        n_cmp++; if (bif.pc_f !== 32'h0000_0000) begin n_bad++; $display("FAIL wrap_mis got %h want 00000000", bif.pc_f); end
        idle();
        bif.jump_valid = 1; bif.jump_target = 32'hFFFF_FFFC;
        tick();
        n_cmp++; if (bif.pc_f !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_jump got %h want fffffffc", bif.pc_f); end
        idle();
        tick();
        n_cmp++; if (bif.pc_f !== 32'h0000_0000) begin n_bad++; $display("FAIL wrap_seq got %h want 00000000", bif.pc_f); end
        n_cmp++; if (bif.branch_cnt !== exp_bcnt) begin n_bad++; $display("FAIL wrap_bcnt got %h want %h", bif.branch_cnt, exp_bcnt); end
        n_cmp++; if (bif.mispred_cnt !== exp_mcnt) begin n_bad++; $display("FAIL wrap_mcnt got %h want %h", bif.mispred_cnt, exp_mcnt); end
        $display("test_wrap done");
    endtask

    initial begin
        test_reset();
        test_training();
        test_mispredict();
        test_priority();
        test_alias();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Next-PC generation and dynamic branch prediction for the RV32I core. Holds the fetch PC, predicts conditional branches in decode with a direct-mapped table of 2-bit saturating counters, and consumes the execute-stage comparator result (`branch_taken`) to train the table and to redirect/squash the pipeline on a misprediction. Also redirects on unconditional jumps resolved in execute and keeps branch/mispredict performance counters.

## Interface
- `RESET_PC`, 32'h4000_0000: fetch PC after reset.
- `IDX_BITS`, 5: table index width; 2^IDX_BITS counters, indexed by PC[IDX_BITS+1:2].
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `stall`  in  1  hazard stall from decode; holds the PC.
- `pc_f`  out  32  current fetch PC (register).
- `d_branch`  in  1  valid conditional-branch instruction in decode.
- `d_pc`  in  32  PC of the decode instruction.
- `d_target`  in  32  branch target (pc + B-imm) computed in decode.
- `d_pred_taken`  out  1  prediction for the decode instruction; carried down the pipeline and returned as `x_pred`.
- `x_valid`  in  1  valid conditional branch in execute; asserted exactly one cycle per branch.
- `x_pc`  in  32  PC of the execute branch.
- `x_target`  in  32  branch target of the execute branch.
- `x_taken`  in  1  comparator result for the execute branch.
- `x_pred`  in  1  prediction made for that branch in decode.
- `jump_valid`  in  1  JAL/JALR resolved in execute.
- `jump_target`  in  32  jump destination.
- `kill_fd`  out  1  squash the instruction entering decode.
- `kill_dx`  out  1  squash the instruction entering execute.
- `branch_cnt`  out  32  count of resolved conditional branches.
- `mispred_cnt`  out  32  count of mispredicted conditional branches.

## Operation
- Table: 2^IDX_BITS 2-bit counters; 00/01 predict not-taken, 10/11 predict taken.
- Lookup (combinational): `d_pred_taken` = `d_branch` & ctr[d_pc idx][1]; reads pre-update table state.
- Mispredict: `mis` = `x_valid` & (`x_taken` != `x_pred`). Correct PC = `x_taken` ? `x_target` : `x_pc`+4 (32-bit, wraps modulo 2^32).
- Next-PC priority, highest first:
  1. `mis` -> correct PC; `kill_fd`=`kill_dx`=1.
  2. `jump_valid` -> `jump_target`; `kill_fd`=`kill_dx`=1.
  3. `stall` -> hold `pc_f`; kills 0.
  4. `d_pred_taken` -> `d_target`; `kill_fd`=1, `kill_dx`=0.
  5. otherwise `pc_f`+4.
- Levels 1-2 override `stall`; level 4 is suppressed by `stall` (decode instruction is not advancing).
- Training: on `x_valid`, ctr[x_pc idx] increments if `x_taken` else decrements, saturating at 11/00. Independent of `stall`, `jump_valid` and `mis`.
- Same-index lookup and update in one cycle: lookup returns old value; update lands at the edge.
- Perf: `branch_cnt` +1 per `x_valid`; `mispred_cnt` +1 per `mis`; both wrap at 2^32.
- `mis` and `jump_valid` together are a pipeline error; branch wins and the table still trains.

## Timing
- Reset (`rst_n`=0 at edge): `pc_f`=`RESET_PC`, every counter=01, `branch_cnt`=`mispred_cnt`=0. Combinational outputs follow inputs during reset; kills are held at 0 while `rst_n`=0.
- Reset asserted mid-operation overrides any redirect or training in that cycle.
- Redirects: inputs in cycle N -> `pc_f` = new PC in cycle N+1. Kills are combinational in cycle N.
- Training: counter change visible to lookups from cycle N+1.
- Perf counters: new value visible in cycle N+1.
- Branch resolved in execute costs 2 bubbles on mispredict, 1 on correctly predicted taken, 0 on correctly predicted not-taken.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles, release -> `pc_f`=4000_0000, then 4000_0004 and 4000_0008 on the next edges; counters 0; `d_pred_taken`=0 for any `d_pc`.
- Training: 2× `x_valid`,`x_taken`=1 at `x_pc`=4000_0040 -> `d_pc`=4000_0040 with `d_branch`=1 gives `d_pred_taken`=1 and `pc_f`=`d_target` next cycle with `kill_fd`=1; 3 not-taken updates -> prediction 0. Counter saturates at 11 and 00.
- Mispredict: `x_pred`=1, `x_taken`=0, `x_pc`=4000_0100 -> `kill_fd`=`kill_dx`=1, next `pc_f`=4000_0104, `mispred_cnt`+1, `branch_cnt`+1.
- Priority: `stall`=1 with `d_pred_taken`=1 -> `pc_f` held, no kill; same cycle plus `jump_valid`=1 to 4000_0200 -> `pc_f`=4000_0200.
- Aliasing / same cycle: update and lookup at same index -> lookup shows old counter; `d_pc`=4000_0080 aliases 4000_0000 (IDX_BITS=5).
- Wrap: `x_pc`=FFFF_FFFC, not taken, `x_pred`=1 -> next `pc_f`=0000_0000; preload perf counter at FFFF_FFFF -> wraps to 0.
